mlp_layer_sequencer: RTL and testbench
======================================

Name: mlp_layer_sequencer

Overview:
- Control-only sequencer for a multi-layer matrix-multiply + ReLU pipeline built around a single shared MAC datapath.
- Holds a small programmable layer table: inner dimension K, output count MN and ReLU enable per layer.
- On start, walks every layer and output element, handshakes operand beats from the operand source and drives MAC clear/enable.
- Flags each finished dot product to the output stage with its layer, index and ReLU select.

Parameters:
MAX_L, 4, maximum number of layers in the table
LW, 2, layer index width (log2 of MAX_L)
DW, 5, width of the inner dimension K
CW, 16, width of the per-layer output count MN and the output index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
cfg_we  input  1  write the layer-table entry at cfg_idx
cfg_idx  input  LW  layer-table entry to write
cfg_k  input  DW  inner dimension (beats per dot product)
cfg_mn  input  CW  output elements in the layer
cfg_relu  input  1  apply ReLU to this layer's outputs
num_layers  input  LW+1  layers to run, 0..MAX_L; sampled on start
start  input  1  begin a run; honoured only in IDLE
busy  output  1  high in RUN, FLUSH and DONE
done  output  1  one-cycle pulse at end of run
op_valid  input  1  operand pair (A, X) available
op_ready  output  1  sequencer accepts an operand beat
mac_clr  output  1  MAC accumulator input selects zero this beat
mac_en  output  1  MAC result register captures this beat
out_valid  output  1  one-cycle pulse: dot product complete
out_relu  output  1  ReLU select for the out_valid result
out_layer  output  LW  layer of the out_valid result
out_idx  output  CW  element index within the layer

Behaviour:
- Reset: async assert on rst=0, sync release.
  - State goes to IDLE; all counters are 0.
  - Every output is 0.
  - Every table entry becomes K=1, MN=1, relu=1.
  - Reset mid-run abandons the run; no done is produced.
- States and transitions:
  - IDLE -> RUN on start. If num_layers=0, go IDLE -> DONE instead.
  - RUN -> FLUSH on the accepted final beat of the last layer.
  - FLUSH -> DONE.
  - DONE -> IDLE.
- Configuration:
  - cfg_we is honoured only in IDLE and ignored otherwise.
  - cfg_k=0 is stored as 1. cfg_mn=0 is stored as 1.
  - num_layers above MAX_L is clamped to MAX_L.
  - start outside IDLE is ignored.
- RUN:
  - op_ready=1 and a beat is accepted when op_valid=1.
  - Counters: k (beat within the dot product), m (element), l (layer).
  - mac_en = op_valid & op_ready, combinational.
  - mac_clr = accepted beat & (k==0), combinational.
  - When op_valid=0 the counters hold and mac_en=0 (stall). Stalls of any length are legal.
- Counter stepping, on an accepted beat:
  - If k==K[l]-1: k<=0 and the beat is a "last beat". Otherwise k<=k+1.
  - On a last beat with m==MN[l]-1: m<=0 and l<=l+1. Otherwise m<=m+1.
  - If that was also l==num_layers-1, go to FLUSH.
- Output timing:
  - out_valid pulses exactly 1 cycle after each last beat is accepted.
  - out_layer, out_idx and out_relu are registered with the beat's l, m and relu. They hold between pulses.
  - A new dot product's first beat may be accepted in the same cycle as out_valid. No bubble is inserted.
- FLUSH: op_ready=0, and the final out_valid occurs here.
- DONE: done=1 for one cycle.
- K=1 case: every beat is both first and last, so mac_clr=1 on every beat and out_valid can pulse every cycle.
- busy: registered from the state; low only in IDLE.

Decomposition:
- Shared package mac_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE};
  - a layer_cfg_t struct {k, mn, relu};
  - default constants MAX_L, DW, CW.
- One sub-module, layer_cfg_table: the register file with a write port and an async read port indexed by l, reset to its defaults.

Test Plan:
- Two-layer run, stall-free:
  - Stimulus: L0 K=3 MN=2 relu=1; L1 K=2 MN=1 relu=0; num_layers=2; start at cycle 0; op_valid held high.
  - Beats are accepted in cycles 1-8; mac_clr is high in cycles 1, 4 and 7.
  - out_valid is high in cycles 4 (L0, idx 0, relu 1), 7 (L0, idx 1, relu 1) and 9 (L1, idx 0, relu 0).
  - done is high in cycle 10; busy is high in cycles 1-10.
- Stall: same config, op_valid=0 in cycles 2-4 -> counters freeze; the first out_valid moves to cycle 7 and done to cycle 13.
- Boundary: K=1 MN=4 single layer, continuous valid -> mac_clr high on all 4 beats (cycles 1-4); out_valid in cycles 2-5 with idx 0..3; done in cycle 6.
- Illegal/ignored inputs:
  - num_layers=0 with start -> done is high in cycle 2 and out_valid never asserts.
  - cfg_k=0 is read back as K=1.
  - cfg_we during busy leaves the table unchanged.
- Reset mid-run: rst=0 at cycle 5 of the first scenario -> all outputs are 0 immediately and no done follows; a fresh start after release runs with the default table (K=1, MN=1).
- start pulsed in cycles 3 and 6 during a run -> ignored; the timing matches the first scenario exactly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MLP layer sequencer and its layer table.
package mac_pkg;

    localparam int MAX_L = 4;
    localparam int LW    = 2;
    localparam int DW    = 5;
    localparam int CW    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DW-1:0] k;
        logic [CW-1:0] mn;
        logic          relu;
    } layer_cfg_t;

    function automatic layer_cfg_t cfg_default();
        layer_cfg_t c;
        c.k    = DW'(1);
        c.mn   = CW'(1);
        c.relu = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/layer_cfg_table.sv
// Programmable layer table: one write port, asynchronous read port.
// Zero K or MN would describe an empty loop, so both are stored as 1.
module layer_cfg_table #(
    parameter int DEPTH = mac_pkg::MAX_L,
    parameter int AW    = mac_pkg::LW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          widx,
    input  logic [mac_pkg::DW-1:0] wk,
    input  logic [mac_pkg::CW-1:0] wmn,
    input  logic                   wrelu,
    input  logic [AW-1:0]          ridx,
    output logic [mac_pkg::DW-1:0] rk,
    output logic [mac_pkg::CW-1:0] rmn,
    output logic                   rrelu
);
    import mac_pkg::*;

    layer_cfg_t tbl [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= cfg_default();
            end
        end else if (we) begin
            tbl[widx].k    <= (wk == '0)  ? DW'(1) : wk;
            tbl[widx].mn   <= (wmn == '0) ? CW'(1) : wmn;
            tbl[widx].relu <= wrelu;
        end
    end

    assign rk    = tbl[ridx].k;
    assign rmn   = tbl[ridx].mn;
    assign rrelu = tbl[ridx].relu;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Walks every layer / output element / inner beat of a shared-MAC MLP pipeline,
// handshaking operand beats and flagging each finished dot product.
module mlp_layer_sequencer #(
    parameter int MAX_L = mac_pkg::MAX_L,
    parameter int LW    = mac_pkg::LW,
    parameter int DW    = mac_pkg::DW,
    parameter int CW    = mac_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [LW-1:0] cfg_idx,
    input  logic [DW-1:0] cfg_k,
    input  logic [CW-1:0] cfg_mn,
    input  logic          cfg_relu,
    input  logic [LW:0]   num_layers,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          op_valid,
    output logic          op_ready,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          out_valid,
    output logic          out_relu,
    output logic [LW-1:0] out_layer,
    output logic [CW-1:0] out_idx
);
    import mac_pkg::*;

    localparam logic [LW:0] MAX_NL = (LW+1)'(MAX_L);

    state_t        state, next_state;
    logic [LW:0]   nl, nl_in;
    logic [DW-1:0] k, cur_k;
    logic [CW-1:0] m, cur_mn;
    logic [LW-1:0] l;
    logic          cur_relu;
    logic          beat, last_k, last_m, last_l;

    assign nl_in = (num_layers > MAX_NL) ? MAX_NL : num_layers;

    layer_cfg_table #(
        .DEPTH (MAX_L),
        .AW    (LW)
    ) u_tbl (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && (state == IDLE)),
        .widx  (cfg_idx),
        .wk    (cfg_k),
        .wmn   (cfg_mn),
        .wrelu (cfg_relu),
        .ridx  (l),
        .rk    (cur_k),
        .rmn   (cur_mn),
        .rrelu (cur_relu)
    );

    assign beat     = (state == RUN) && op_valid;
    assign last_k   = (k == cur_k - DW'(1));
    assign last_m   = (m == cur_mn - CW'(1));
    assign last_l   = ({1'b0, l} == nl - (LW+1)'(1));
    assign op_ready = (state == RUN);
    assign mac_en   = beat;
    assign mac_clr  = beat && (k == '0);
    assign done     = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (nl_in == '0) ? DONE : RUN;
            RUN:     if (beat && last_k && last_m && last_l) next_state = FLUSH;
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // Result tags are captured with the last beat so the output stage sees them
    // alongside out_valid one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nl        <= '0;
            k         <= '0;
            m         <= '0;
            l         <= '0;
            out_valid <= 1'b0;
            out_relu  <= 1'b0;
            out_layer <= '0;
            out_idx   <= '0;
        end else begin
            out_valid <= beat && last_k;
            if (beat && last_k) begin
                out_layer <= l;
                out_idx   <= m;
                out_relu  <= cur_relu;
            end
            if ((state == IDLE) && start) begin
                nl <= nl_in;
                k  <= '0;
                m  <= '0;
                l  <= '0;
            end else if (beat) begin
                if (last_k) begin
                    k <= '0;
                    if (last_m) begin
                        m <= '0;
                        l <= l + LW'(1);
                    end else begin
                        m <= m + CW'(1);
                    end
                end else begin
                    k <= k + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer: an independent beat-list model
// predicts MAC strobes, result tags/timing, busy and done cycle by cycle.
module tb_mlp_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [4:0]  cfg_k;
    logic [15:0] cfg_mn;
    logic        cfg_relu;
    logic [2:0]  num_layers;
    logic        start;
    logic        busy, done;
    logic        op_valid, op_ready;
    logic        mac_clr, mac_en;
    logic        out_valid, out_relu;
    logic [1:0]  out_layer;
    logic [15:0] out_idx;

    mlp_layer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_k      (cfg_k),
        .cfg_mn     (cfg_mn),
        .cfg_relu   (cfg_relu),
        .num_layers (num_layers),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .out_valid  (out_valid),
        .out_relu   (out_relu),
        .out_layer  (out_layer),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int layer; int idx; int relu;} exp_t;
    typedef struct {int l; int m; int k; int last;} beat_t;

    exp_t  sb[$];
    beat_t beats[$];
    int    bk[4], bmn[4], brelu[4];
    int    n_vec = 0;
    int    n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_table_defaults();
        for (int i = 0; i < 4; i++) begin
            bk[i] = 1; bmn[i] = 1; brelu[i] = 1;
        end
    endtask

    task automatic cfg_write(input int idx, input int kk, input int mn, input int relu);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_k = 5'(kk); cfg_mn = 16'(mn); cfg_relu = relu[0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        bk[idx]    = (kk == 0) ? 1 : kk;
        bmn[idx]   = (mn == 0) ? 1 : mn;
        brelu[idx] = relu;
    endtask

    // One scenario: start/stall/extra-start/busy-write/reset cycles are relative to cycle 0.
    task automatic run(input int nl, input int start_cyc, input int stall_lo, input int stall_hi,
                       input int xs1, input int xs2, input int wr_cyc, input int rst_cyc,
                       input int ncyc, input string name);
        int    nlc, bi, done_cyc, exp_en, exp_clr, exp_rdy, exp_busy;
        bit    dead;
        beat_t b;
        nlc = (nl > 4) ? 4 : nl;
        beats.delete();
        sb.delete();
        for (int li = 0; li < nlc; li++)
            for (int mi = 0; mi < bmn[li]; mi++)
                for (int ki = 0; ki < bk[li]; ki++)
                    beats.push_back('{li, mi, ki, (ki == bk[li] - 1) ? 1 : 0});
        bi = 0;
        dead = 1'b0;
        done_cyc = (nlc == 0) ? start_cyc + 1 : -1;
        num_layers = 3'(nl);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start    = (c == start_cyc) || (c == xs1) || (c == xs2);
            op_valid = !((c >= stall_lo) && (c <= stall_hi));
            cfg_we   = (c == wr_cyc);
            cfg_idx  = 2'd0; cfg_k = 5'd7; cfg_mn = 16'd3; cfg_relu = 1'b0;
            if (c == rst_cyc) begin
                rst = 1'b0;
                dead = 1'b1;
                sb.delete();
                done_cyc = -1;
                model_table_defaults();
            end
            exp_rdy = (!dead && c > start_cyc && bi < beats.size()) ? 1 : 0;
            exp_busy = (!dead && c > start_cyc && (done_cyc < 0 || c <= done_cyc)) ? 1 : 0;
            exp_en = 0; exp_clr = 0;
            if (exp_rdy != 0 && op_valid) begin
                b = beats[bi];
                bi++;
                exp_en = 1;
                exp_clr = (b.k == 0) ? 1 : 0;
                if (b.last != 0) sb.push_back('{c + 1, b.l, b.m, brelu[b.l]});
                if (bi == beats.size()) done_cyc = c + 2;
            end
            @(negedge clk);
            chk($sformatf("%s c%0d mac_en", name, c), 32'(mac_en), exp_en);
            chk($sformatf("%s c%0d mac_clr", name, c), 32'(mac_clr), exp_clr);
            chk($sformatf("%s c%0d op_ready", name, c), 32'(op_ready), exp_rdy);
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), exp_busy);
            chk($sformatf("%s c%0d done", name, c), 32'(done), (c == done_cyc) ? 1 : 0);
            if (sb.size() > 0 && sb[0].cyc == c) begin
                chk($sformatf("%s c%0d out_valid", name, c), 32'(out_valid), 1);
                chk($sformatf("%s c%0d out_layer", name, c), 32'(out_layer), sb[0].layer);
                chk($sformatf("%s c%0d out_idx", name, c), 32'(out_idx), sb[0].idx);
                chk($sformatf("%s c%0d out_relu", name, c), 32'(out_relu), sb[0].relu);
                void'(sb.pop_front());
            end else begin
                chk($sformatf("%s c%0d out_valid", name, c), 32'(out_valid), 0);
            end
            if (dead) begin
                chk($sformatf("%s c%0d rst out_layer", name, c), 32'(out_layer), 0);
                chk($sformatf("%s c%0d rst out_idx", name, c), 32'(out_idx), 0);
                chk($sformatf("%s c%0d rst out_relu", name, c), 32'(out_relu), 0);
            end
        end
        start = 1'b0; op_valid = 1'b0; cfg_we = 1'b0;
        if (!rst) begin
            @(posedge clk); #1;
            rst = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_k = '0; cfg_mn = '0; cfg_relu = 1'b0;
        num_layers = '0; start = 1'b0; op_valid = 1'b0;
        model_table_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset op_ready", 32'(op_ready), 0);
        chk("reset out_idx", 32'(out_idx), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Two-layer run, then stall, then ignored starts + busy write, then a clean rerun.
        cfg_write(0, 3, 2, 1);
        cfg_write(1, 2, 1, 0);
        run(2, 0, -1, -1, -1, -1, -1, -1, 14, "two_layer");
        run(2, 0, 2, 4, -1, -1, -1, -1, 18, "stall");
        run(2, 0, -1, -1, 3, 6, 5, -1, 14, "ignored_in");
        run(2, 0, -1, -1, -1, -1, -1, -1, 14, "rerun");

        // K=1 boundary: every beat is first and last.
        cfg_write(0, 1, 4, 0);
        run(1, 0, -1, -1, -1, -1, -1, -1, 10, "k1");

        // K written as 0 behaves as K=1.
        cfg_write(0, 0, 3, 1);
        run(1, 0, -1, -1, -1, -1, -1, -1, 8, "k0");

        // No layers: straight to done, no results.
        run(0, 1, -1, -1, -1, -1, -1, -1, 6, "nl0");

        // num_layers above the table depth clamps to four layers.
        cfg_write(0, 1, 1, 1);
        cfg_write(1, 1, 1, 0);
        cfg_write(2, 1, 1, 1);
        cfg_write(3, 2, 1, 0);
        run(7, 0, -1, -1, -1, -1, -1, -1, 10, "clamp");

        // Reset mid-run abandons the run and restores the default table.
        cfg_write(0, 3, 2, 1);
        cfg_write(1, 2, 1, 0);
        run(2, 0, -1, -1, -1, -1, -1, 5, 10, "rst_mid");
        run(1, 0, -1, -1, -1, -1, -1, -1, 6, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
